counter_sequencer: RTL

//   FSM controller that sequences a WIDTH-bit up-counter via start/stop/clear commands.

---
 rtl/counter_sequencer_if.sv | 25 ++
 rtl/counter_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/counter_sequencer_if.sv
// Command/status bundle between the push-button/switch logic and the counter sequencer.
// The master issues run commands and the terminal value; the slave returns count and status.
interface counter_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             clear;
  logic             reload;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output start, stop, clear, reload, term,
    input  count, busy, done, wrap
  );

  modport slave (
    input  start, stop, clear, reload, term,
    output count, busy, done, wrap
  );
endinterface

// File: rtl/counter_sequencer.sv
// Start/stop/clear sequencer for a WIDTH-bit up-counter with one-shot or auto-reload runs.
// Optional count-step prescaler enabled by defining CNT_PRESCALE_EN.
module counter_sequencer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                clk,
  input  logic                reset,
  counter_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             tick;

  if (PRESCALE == 0) begin : g_bad_prescale
    $error("counter_sequencer: PRESCALE must be >= 1");
  end

`ifdef CNT_PRESCALE_EN
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q;

  assign tick = (ps_q == PS_LAST);

  // Phase advances only while staying in RUN, holds through PAUSE, and is zero outside a run.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q <= '0;
    end else if (state_d != RUN && state_d != PAUSE) begin
      ps_q <= '0;
    end else if (state_q == RUN && state_d == RUN) begin
      ps_q <= tick ? '0 : ps_q + PS_W'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      term_q   <= '0;
      reload_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      term_q   <= term_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
    end
  end

  // Command priority is clear > stop > start; stop has no meaning outside RUN/PAUSE.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    term_d   = term_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.clear) begin
          state_d = IDLE;
          count_d = '0;
        end else if (bus.start) begin
          state_d  = RUN;
          count_d  = '0;
          term_d   = bus.term;
          reload_d = bus.reload;
        end
      end
      RUN: begin
        if (bus.clear) begin
          state_d = IDLE;
          count_d = '0;
        end else if (bus.stop) begin
          state_d = PAUSE;
        end else if (tick) begin
          if (count_q != term_q) begin
            count_d = count_q + WIDTH'(1);
          end else if (reload_q) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (bus.clear) begin
          state_d = IDLE;
          count_d = '0;
        end else if (!bus.stop && bus.start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == PAUSE);
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.wrap  = wrap_q;

endmodule
